// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the processor/display requesters, the arbiter and the dmem syncram.
interface dmem_port_arbiter_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned DATA_W = 32
);
  logic              p_req;
  logic              p_wren;
  logic [ADDR_W-1:0] p_addr;
  logic [DATA_W-1:0] p_wdata;
  logic              p_stall;
  logic [DATA_W-1:0] p_rdata;

  logic              d_req;
  logic [ADDR_W-1:0] d_addr;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;

  logic [15:0]       starve_cnt;

  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_data;
  logic              mem_wren;
  logic [DATA_W-1:0] mem_q;

  modport slave (
    input  p_req, p_wren, p_addr, p_wdata, d_req, d_addr, mem_q,
    output p_stall, p_rdata, d_gnt, d_rvalid, d_rdata, starve_cnt,
           mem_addr, mem_data, mem_wren
  );

  modport master (
    output p_req, p_wren, p_addr, p_wdata, d_req, d_addr, mem_q,
    input  p_stall, p_rdata, d_gnt, d_rvalid, d_rdata, starve_cnt,
           mem_addr, mem_data, mem_wren
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Shares the single-port dmem between the processor (priority) and a read-only display
// requester; the display is forced through after MAX_WAIT ungranted cycles.
module dmem_port_arbiter #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned MAX_WAIT = 8
) (
  input logic                 clock,
  input logic                 reset,
  dmem_port_arbiter_if.slave  bus
);

  localparam logic [7:0] MAX_W8 = 8'(MAX_WAIT);

  logic [7:0]        wait_cnt;
  logic              d_rvalid_q;
  logic [15:0]       starve_q;
  logic              force_grant;
  logic              d_gnt_c;
  logic [ADDR_W-1:0] addr_sel;
  logic [DATA_W-1:0] rdata;

  always_comb begin
    force_grant = bus.d_req && (wait_cnt == MAX_W8);
    d_gnt_c     = reset && bus.d_req && (!bus.p_req || force_grant);
    addr_sel    = d_gnt_c ? bus.d_addr : bus.p_addr;
    rdata       = bus.mem_q;
  end

  assign bus.d_gnt      = d_gnt_c;
  assign bus.p_stall    = reset && bus.p_req && d_gnt_c;
  assign bus.mem_addr   = addr_sel;
  assign bus.mem_data   = bus.p_wdata;
  assign bus.mem_wren   = reset && bus.p_req && bus.p_wren && !d_gnt_c;
  assign bus.d_rvalid   = d_rvalid_q;
  assign bus.d_rdata    = rdata;
  assign bus.p_rdata    = rdata;
  assign bus.starve_cnt = starve_q;

  always_ff @(posedge clock) begin
    if (!reset) begin
      wait_cnt   <= '0;
      d_rvalid_q <= 1'b0;
      starve_q   <= '0;
    end else begin
      d_rvalid_q <= d_gnt_c;
      if (!bus.d_req || d_gnt_c)
        wait_cnt <= '0;
      else if (wait_cnt != MAX_W8)
        wait_cnt <= wait_cnt + 8'd1;
      // Only forced grants that actually displaced a processor access count as starvation.
      if (force_grant && bus.p_req && (starve_q != '1))
        starve_q <= starve_q + 16'd1;
    end
  end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter with a behavioural syncram and reference model.
module tb_dmem_port_arbiter;
  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned MW = 3;

  typedef struct {
    int unsigned   due;
    logic [DW-1:0] data;
  } item_t;

  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  dmem_port_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  dmem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_WAIT(MW)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // Environment syncram: registered read, read-before-write.
  logic [DW-1:0] ram [0:(1<<AW)-1];
  always @(posedge clock) begin
    if (bus.mem_wren) ram[bus.mem_addr] <= bus.mem_data;
    bus.mem_q <= ram[bus.mem_addr];
  end

  int unsigned errors = 0;
  int unsigned checks = 0;
  int unsigned cyc    = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Reference model state
  logic [DW-1:0] ref_mem [0:63];
  int unsigned   waited = 0;
  int unsigned   starve = 0;
  bit            armed  = 0;
  item_t         dq[$];
  item_t         pq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input logic rst_v, input logic preq, input logic pwren,
                      input logic [AW-1:0] paddr, input logic [DW-1:0] pwdata,
                      input logic dreq, input logic [AW-1:0] daddr,
                      input bit drop_rst, output logic gnt);
    logic fm, gm, sm, wm;
    bit   rst_e;
    reset       = rst_v;
    bus.p_req   = preq;
    bus.p_wren  = pwren;
    bus.p_addr  = paddr;
    bus.p_wdata = pwdata;
    bus.d_req   = dreq;
    bus.d_addr  = daddr;
    @(negedge clock);
    fm = dreq && (waited == MW);
    gm = rst_v && dreq && (!preq || fm);
    sm = rst_v && preq && gm;
    wm = rst_v && preq && pwren && !gm;
    chk("d_gnt", 32'(bus.d_gnt), 32'(gm));
    chk("p_stall", 32'(bus.p_stall), 32'(sm));
    chk("mem_wren", 32'(bus.mem_wren), 32'(wm));
    if (gm || preq) chk("mem_addr", 32'(bus.mem_addr), 32'(gm ? daddr : paddr));
    if (wm) chk("mem_data", bus.mem_data, pwdata);
    if (armed) begin
      chk("starve_cnt", 32'(bus.starve_cnt), starve);
      chk("wait_cnt", 32'(dut.wait_cnt), waited);
    end
    if (gm && !drop_rst) dq.push_back('{cyc + 1, ref_mem[daddr[5:0]]});
    if (rst_v && preq && !pwren && !gm) pq.push_back('{cyc + 1, ref_mem[paddr[5:0]]});
    if (wm) ref_mem[paddr[5:0]] = pwdata;
    if (drop_rst) reset = 1'b0;
    rst_e = rst_v && !drop_rst;
    @(posedge clock);
    if (!rst_e) begin
      waited = 0;
      starve = 0;
      armed  = 1;
    end else begin
      if (!dreq || gm) waited = 0;
      else if (waited < MW) waited++;
      if (fm && preq && starve < 32'hFFFF) starve++;
    end
    gnt = gm;
    #1;
  endtask

  // Monitor: pops expected responses whenever the DUT presents read data.
  always @(negedge clock) begin
    item_t it;
    if (bus.d_rvalid === 1'b1) begin
      if (dq.size() != 0 && dq[0].due == cyc) begin
        it = dq.pop_front();
        chk("d_rdata", bus.d_rdata, it.data);
      end else begin
        chk("d_rvalid_spurious", 32'(bus.d_rvalid), 32'd0);
      end
    end else if (dq.size() != 0 && dq[0].due == cyc) begin
      void'(dq.pop_front());
      chk("d_rvalid_missing", 32'(bus.d_rvalid), 32'd1);
    end
    if (pq.size() != 0 && pq[0].due == cyc) begin
      it = pq.pop_front();
      chk("p_rdata", bus.p_rdata, it.data);
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic g;
    logic pend, dreq, preq, pwren, rst_v;
    logic [AW-1:0] da;
    bus.p_req = 0; bus.p_wren = 0; bus.p_addr = '0; bus.p_wdata = '0;
    bus.d_req = 0; bus.d_addr = '0;
    for (int unsigned i = 0; i < 64; i++) ref_mem[i] = '0;

    // Reset with both requesters active: nothing may be granted or written.
    repeat (3) step(0, 1, 1, 12'h005, 32'h1234_5678, 1, 12'h006, 0, g);

    // Fill the address window so every later read has a known value.
    for (int unsigned a = 0; a < 64; a++) step(1, 1, 1, AW'(a), $urandom, 0, '0, 0, g);

    // Processor only: store then load.
    step(1, 1, 1, 12'h010, 32'hDEAD_BEEF, 0, '0, 0, g);
    step(1, 1, 0, 12'h010, '0, 0, '0, 0, g);
    step(1, 0, 0, '0, '0, 0, '0, 0, g);

    // Display only: immediate grant, data one cycle later.
    step(1, 0, 0, '0, '0, 1, 12'h010, 0, g);
    step(1, 0, 0, '0, '0, 0, '0, 0, g);

    // Starvation, with a store arriving exactly on the forced cycle.
    for (int unsigned i = 0; i < 3; i++) step(1, 1, 0, AW'($urandom_range(0, 63)), '0, 1, 12'h020, 0, g);
    step(1, 1, 1, 12'h030, 32'h5, 1, 12'h020, 0, g);
    step(1, 1, 1, 12'h030, 32'h5, 0, '0, 0, g);
    step(1, 1, 0, 12'h030, '0, 0, '0, 0, g);
    step(1, 0, 0, '0, '0, 0, '0, 0, g);

    // Reset right after a display grant: the read must be dropped.
    step(1, 0, 0, '0, '0, 1, 12'h011, 1, g);
    step(1, 0, 0, '0, '0, 0, '0, 0, g);
    step(1, 0, 0, '0, '0, 0, '0, 0, g);

    // Saturation: preload starve_cnt just below the ceiling.
    force dut.starve_q = 16'hFFFE;
    #1;
    release dut.starve_q;
    starve = 32'hFFFE;
    repeat (3) begin
      for (int unsigned i = 0; i < 4; i++) step(1, 1, 0, AW'($urandom_range(0, 63)), '0, 1, 12'h021, 0, g);
    end
    step(1, 0, 0, '0, '0, 0, '0, 0, g);

    // Randomized traffic.
    pend = 0;
    da   = '0;
    for (int unsigned n = 0; n < 800; n++) begin
      if (!pend && $urandom_range(0, 2) == 0) begin
        pend = 1;
        da   = AW'($urandom_range(0, 63));
      end
      dreq = pend;
      if (pend && $urandom_range(0, 49) == 0) begin
        dreq = 0;
        pend = 0;
      end
      preq  = ($urandom_range(0, 9) < 7);
      pwren = ($urandom_range(0, 2) == 0);
      rst_v = ($urandom_range(0, 199) != 0);
      step(rst_v, preq, pwren, AW'($urandom_range(0, 63)), $urandom, dreq, da, 0, g);
      if (g) pend = 0;
    end

    repeat (3) step(1, 0, 0, '0, '0, 0, '0, 0, g);
    chk("dq_drained", dq.size(), 32'd0);
    chk("pq_drained", pq.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Shares the single-port data memory (dmem) between the processor and a read-only display requester, such as the VGA snake renderer fetching board words. The processor has priority. The display is served in idle processor cycles, or by a forced cycle that stalls the processor once the display has waited `MAX_WAIT` cycles. The block sits between the processor's dmem port and the dmem syncram inside the top-level skeleton, and steers the returned read data to the correct requester.

## Interface
Parameters:
- `ADDR_W`, 12: dmem address width.
- `DATA_W`, 32: dmem data width.
- `MAX_WAIT`, 8: consecutive ungranted display cycles before a forced display grant; legal range 1..255.

Ports:
- `clock`  in  1: single clock; all state updates on the rising edge.
- `reset`  in  1: synchronous, active-low.
- `p_req`  in  1: processor accesses dmem this cycle (load or store).
- `p_wren`  in  1: processor store; qualified by `p_req`.
- `p_addr`  in  `ADDR_W`: processor address.
- `p_wdata`  in  `DATA_W`: processor store data.
- `p_stall`  out  1: processor must hold its access and retry next cycle.
- `p_rdata`  out  `DATA_W`: processor load data.
- `d_req`  in  1: display read request, held until granted.
- `d_addr`  in  `ADDR_W`: display address, stable while `d_req`=1 and `d_gnt`=0.
- `d_gnt`  out  1: display address is on the dmem port this cycle.
- `d_rvalid`  out  1: `d_rdata` is valid this cycle.
- `d_rdata`  out  `DATA_W`: display read data.
- `starve_cnt`  out  16: number of forced display grants; saturating; debug only.
- `mem_addr`  out  `ADDR_W`: to dmem.
- `mem_data`  out  `DATA_W`: to dmem.
- `mem_wren`  out  1: to dmem.
- `mem_q`  in  `DATA_W`: from dmem; valid one cycle after its address is presented.

## Operation
- Registered state: `wait_cnt` (8 bit), `d_rvalid`, `starve_cnt`.
- `force = d_req & (wait_cnt == MAX_WAIT)`.
- `d_gnt = reset & d_req & (~p_req | force)`.
- `p_stall = reset & p_req & d_gnt`. This is nonzero only on a forced cycle.
- Address steering: `mem_addr = d_gnt ? d_addr : p_addr`.
- Write data: `mem_data = p_wdata` always.
- Write enable: `mem_wren = reset & p_req & p_wren & ~d_gnt`. The display never writes.
- `wait_cnt` update, per cycle:
  - Cleared when `d_req`=0 or `d_gnt`=1.
  - Otherwise incremented, saturating at `MAX_WAIT`.
- `d_rvalid` is `d_gnt` registered.
- `d_rdata = mem_q`; it is meaningful only while `d_rvalid`=1.
- `p_rdata = mem_q` as a passthrough; the processor samples it under its own load timing.
- `starve_cnt` increments on every cycle with `force & p_req`, saturating at 0xFFFF.
  - A force cycle with `p_req`=0 is an ordinary idle grant and is not counted.
- Boundaries:
  - `d_req` and `p_req` both high below threshold: the processor wins and `wait_cnt` advances.
  - Threshold reached: exactly one forced grant, then `wait_cnt` returns to 0, so the processor is stalled for at most 1 of every `MAX_WAIT`+1 cycles.
  - Back-to-back display requests: one grant per cycle when the processor is idle.
  - `d_req` dropped before grant is a protocol violation; the block only clears `wait_cnt`.

## Timing
- Grant and steering are combinational in the request cycle; `mem_addr` and `mem_wren` go to dmem the same cycle.
- Display read latency: `d_rvalid` and `d_rdata` appear exactly 1 cycle after `d_gnt`.
- A stalled processor access completes, at the earliest, in the cycle after the stall.
- Reset (`reset`=0, sampled on a clock edge) sets:
  - `wait_cnt`=0, `d_rvalid`=0, `starve_cnt`=0.
  - While `reset`=0: `d_gnt`=0, `p_stall`=0, `mem_wren`=0.
- Reset mid-operation: an outstanding display read whose grant was in the cycle before the reset edge is dropped; `d_rvalid` is 0 after the edge.

## Test plan
All scenarios use `MAX_WAIT`=3.
- Processor only: store 0xDEADBEEF at 0x010, then load 0x010. Required: `mem_wren`=1 for one cycle, `p_rdata`=0xDEADBEEF one cycle after the load, `d_gnt` never asserted.
- Display only: `d_req` at 0x010 with `p_req`=0. Required: `d_gnt` in the same cycle, then `d_rvalid`=1 with `d_rdata`=0xDEADBEEF one cycle later, `wait_cnt` staying at 0.
- Starvation: `p_req` held at 1 and `d_req` at 0x020 asserted. Required:
  - 3 cycles with `d_gnt`=0.
  - 4th cycle: `d_gnt`=1, `p_stall`=1, `mem_addr`=0x020, `mem_wren`=0.
  - Then `starve_cnt`=1 and `wait_cnt`=0.
- Forced-cycle store blocked: at the threshold cycle, the processor stores 0x5 to 0x030. Required: no write that cycle; the retried store next cycle writes 0x5, confirmed by a later readback.
- Reset mid-read: `d_gnt` in cycle N, then `reset`=0 sampled at the end of cycle N. Required: `d_rvalid`=0 in cycle N+1, and all counters read 0.
- Saturation: force `starve_cnt` to 0xFFFF by running a long contention loop (or preloading it in the testbench). Required: it holds 0xFFFF on further forced grants.
